// File: rtl/event_fifo_pkg.sv
// event_fifo_pkg: shared defaults, types and pointer sizing for event_fifo.
package event_fifo_pkg;

  localparam int DEF_DATA_W          = 64;
  localparam int DEF_WORDS_PER_EVENT = 16;

  typedef logic [DEF_DATA_W-1:0] fifo_word_t;

  // Address bits plus one wrap bit.
  function automatic int clog2_ptr(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, registered read, array never reset
// so it maps onto block RAM; only the output register is cleared.
module fifo_ram #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/event_fifo.sv
// event_fifo: word FIFO that also tracks complete events for the reader.
// Optional parity per word under EVENT_FIFO_ECC_EN.
module event_fifo
  import event_fifo_pkg::*;
#(
  parameter int DEPTH           = 1024,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int WORDS_PER_EVENT = DEF_WORDS_PER_EVENT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en_i,
  input  logic [DATA_W-1:0]           din_i,
  output logic                        full_o,
  output logic                        prog_full_o,
  input  logic                        rd_en_i,
  output logic [DATA_W-1:0]           dout_o,
  output logic                        empty_o,
  output logic [clog2_ptr(DEPTH)-1:0] data_count_o,
  output logic [clog2_ptr(DEPTH)-1:0] event_count_o,
  output logic                        overflow_o,
  output logic                        underflow_o
`ifdef EVENT_FIFO_ECC_EN
  ,
  output logic                        parity_err_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = clog2_ptr(DEPTH);
  localparam int WC_W   =
    (WORDS_PER_EVENT > 1) ? $clog2(WORDS_PER_EVENT) : 1;

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] WPE_P   = PTR_W'(WORDS_PER_EVENT);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WORDS_PER_EVENT - 1);

`ifdef EVENT_FIFO_ECC_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n;
  logic [PTR_W-1:0] cnt_n, ev_n;
  logic [WC_W-1:0]  wr_wc, rd_wc;
  logic             wr_acc, rd_acc;
  logic             ev_done, ev_cons;
  logic             full_n, empty_n, pfull_n;
  logic [RAM_W-1:0] ram_wd, ram_q;

  assign wr_acc  = wr_en_i & ~full_o;
  assign rd_acc  = rd_en_i & ~empty_o;
  assign ev_done = wr_acc & (wr_wc == WC_LAST);
  assign ev_cons = rd_acc & (rd_wc == WC_LAST);

  always_comb begin
    wr_ptr_n = wr_ptr + PTR_W'(wr_acc);
    rd_ptr_n = rd_ptr + PTR_W'(rd_acc);
    cnt_n    = wr_ptr_n - rd_ptr_n;
    empty_n  = (wr_ptr_n == rd_ptr_n);
    full_n   =
      (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]) &&
      (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]);
    pfull_n  = (DEPTH_P - cnt_n) < WPE_P;
    ev_n     = event_count_o
             + PTR_W'(ev_done)
             - PTR_W'(ev_cons);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_wc         <= '0;
      rd_wc         <= '0;
      data_count_o  <= '0;
      event_count_o <= '0;
      empty_o       <= 1'b1;
      full_o        <= 1'b0;
      prog_full_o   <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      data_count_o  <= cnt_n;
      event_count_o <= ev_n;
      empty_o       <= empty_n;
      full_o        <= full_n;
      prog_full_o   <= pfull_n;
      if (wr_acc)
        wr_wc <= (wr_wc == WC_LAST) ? '0 : wr_wc + 1'b1;
      if (rd_acc)
        rd_wc <= (rd_wc == WC_LAST) ? '0 : rd_wc + 1'b1;
      if (wr_en_i && full_o)
        overflow_o <= 1'b1;
      if (rd_en_i && empty_o)
        underflow_o <= 1'b1;
    end
  end

`ifdef EVENT_FIFO_ECC_EN
  logic rd_vld;

  assign ram_wd = {^din_i, din_i};

  always_ff @(posedge clk) begin
    if (reset) rd_vld <= 1'b0;
    else       rd_vld <= rd_acc;
  end

  // Even parity over data+parity bit; only meaningful on a fresh read.
  assign parity_err_o = rd_vld & (^ram_q);
`else
  assign ram_wd = din_i;
`endif

  assign dout_o = ram_q[DATA_W-1:0];

  fifo_ram #(
    .WIDTH  (RAM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc & ~reset),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (ram_wd),
    .re    (rd_acc & ~reset),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_event_fifo.sv
// tb_event_fifo: directed + random checks of event_fifo against a queue model.
module tb_event_fifo;
  import event_fifo_pkg::*;

  localparam int DEPTH = 64;
  localparam int WPE   = 16;
  localparam int CW    = clog2_ptr(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  fifo_word_t    din = '0;
  fifo_word_t    dout;
  logic          full, prog_full, empty, ovf, unf;
  logic [CW-1:0] dcount, ecount;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_word_t m_q[$];
  fifo_word_t m_dout;
  int         m_wr, m_rd;
  bit         m_ovf, m_unf;

  always #4 clk = ~clk;

  event_fifo #(
    .DEPTH           (DEPTH),
    .DATA_W          (64),
    .WORDS_PER_EVENT (WPE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (wr_en),
    .din_i         (din),
    .full_o        (full),
    .prog_full_o   (prog_full),
    .rd_en_i       (rd_en),
    .dout_o        (dout),
    .empty_o       (empty),
    .data_count_o  (dcount),
    .event_count_o (ecount),
    .overflow_o    (ovf),
    .underflow_o   (unf)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, ":dcount"}, 64'(dcount), 64'(sz));
    check({tag, ":ecount"}, 64'(ecount),
          64'((m_wr / WPE) - (m_rd / WPE)));
    check({tag, ":empty"}, 64'(empty), 64'(sz == 0));
    check({tag, ":full"}, 64'(full), 64'(sz == DEPTH));
    check({tag, ":pfull"}, 64'(prog_full),
          64'((DEPTH - sz) < WPE));
    check({tag, ":ovf"}, 64'(ovf), 64'(m_ovf));
    check({tag, ":unf"}, 64'(unf), 64'(m_unf));
    check({tag, ":dout"}, dout, m_dout);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_dout = '0;
    m_wr = 0;
    m_rd = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock with the given strobes; model advances from pre-edge state.
  task automatic cycle(input logic wr, input fifo_word_t d,
                       input logic rd, input string tag);
    bit wacc, racc;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    wacc = wr && (m_q.size() < DEPTH);
    racc = rd && (m_q.size() > 0);
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && !racc) m_unf = 1'b1;
    @(posedge clk);
    #1;
    if (racc) begin
      m_dout = m_q.pop_front();
      m_rd++;
    end
    if (wacc) begin
      m_q.push_back(d);
      m_wr++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int guard;
    fifo_word_t w;

    // reset state
    do_reset();
    check_all("reset");

    // one event in, one event out
    for (int i = 0; i < WPE; i++)
      cycle(1'b1, fifo_word_t'(i), 1'b0, "ev_wr");
    check("ev_wr_ecount", 64'(ecount), 64'd1);
    for (int i = 0; i < WPE; i++) begin
      cycle(1'b0, '0, 1'b1, "ev_rd");
      check("ev_rd_data", dout, 64'(i));
    end
    check("ev_rd_empty", 64'(empty), 64'd1);

    // fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      w = {$urandom, $urandom};
      cycle(1'b1, w, 1'b0, "fill");
    end
    check("fill_full", 64'(full), 64'd1);
    cycle(1'b1, 64'hdead_beef, 1'b0, "wr65");
    check("wr65_ovf", 64'(ovf), 64'd1);
    check("wr65_dcount", 64'(dcount), 64'd64);

    // full: read accepted, write rejected
    cycle(1'b1, 64'h1234, 1'b1, "full_rw");
    check("full_rw_dcount", 64'(dcount), 64'd63);

    // empty: underflow, then simultaneous write+read
    do_reset();
    cycle(1'b0, '0, 1'b1, "rd_empty");
    check("rd_empty_unf", 64'(unf), 64'd1);
    cycle(1'b1, 64'habcd, 1'b1, "empty_rw");
    check("empty_rw_empty", 64'(empty), 64'd0);
    cycle(1'b0, '0, 1'b1, "empty_rw_rd");
    check("empty_rw_data", dout, 64'habcd);

    // random stream of 200 words across pointer wrap
    do_reset();
    guard = 0;
    while (m_wr < 200 && guard < 4000) begin
      w = {$urandom, $urandom};
      cycle(($urandom_range(0, 99) < 60), w,
            ($urandom_range(0, 99) < 50), "rand");
      guard++;
    end
    check("rand_budget", 64'(m_wr >= 200), 64'd1);
    guard = 0;
    while (m_q.size() > 0 && guard < 200) begin
      cycle(1'b0, '0, 1'b1, "drain");
      guard++;
    end
    check("drain_empty", 64'(empty), 64'd1);

    // reset mid-event
    do_reset();
    for (int i = 0; i < 7; i++)
      cycle(1'b1, fifo_word_t'(i + 100), 1'b0, "part");
    do_reset();
    check_all("mid_reset");
    for (int i = 0; i < WPE; i++)
      cycle(1'b1, fifo_word_t'(i + 200), 1'b0, "after_rst");
    check("after_rst_ecount", 64'(ecount), 64'd1);
    cycle(1'b0, '0, 1'b1, "after_rst_rd");
    check("after_rst_first", dout, 64'd200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/event_fifo.md
Name: event_fifo

Overview:
- Single-clock event buffer on the 125 MHz domain.
- Sits between event_saver (write side: wr_en/din/full) and event_reader (read side: rd_en/dout/empty).
- Stores 64-bit words and tracks how many complete events (WORDS_PER_EVENT words each) are held.
- Gives the writer a prog-full flag so it never starts an event it cannot finish.

Parameters:
- DEPTH, 1024, number of 64-bit words stored; must be a power of two, at least 2*WORDS_PER_EVENT.
- DATA_W, 64, word width.
- WORDS_PER_EVENT, 16, words making one complete event.

Ports:
- clk  in  1  125 MHz clock.
- reset  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write strobe.
- din_i  in  DATA_W  write data.
- full_o  out  1  no free word.
- prog_full_o  out  1  free words < WORDS_PER_EVENT.
- rd_en_i  in  1  read strobe.
- dout_o  out  DATA_W  read data, valid 1 cycle after an accepted read.
- empty_o  out  1  no stored word.
- data_count_o  out  $clog2(DEPTH)+1  words stored.
- event_count_o  out  $clog2(DEPTH)+1  complete events stored and not yet fully read.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high.
- All state is registered on the rising edge of clk.
- Reset state: pointers, counts, word counters and sticky flags = 0; empty_o=1; full_o=0; prog_full_o=0; dout_o=0. RAM contents are not cleared.
- Reset mid-operation discards all stored data. The first write after reset starts a new event.
- Write accept: wr_en_i && !full_o. Accepted data goes to mem[wr_ptr] and wr_ptr increments.
- Rejected write: RAM and pointers unchanged; overflow_o set.
- Read accept: rd_en_i && !empty_o. dout_o <= mem[rd_ptr] on the next edge and rd_ptr increments.
- Rejected read: dout_o holds its value; underflow_o set.
- Write attempt while full is rejected even if a read is accepted in the same cycle. Full clears the next cycle.
- Read attempt while empty is rejected even if a write is accepted in the same cycle. empty_o drops the next cycle, so write-to-readable latency is 1 cycle.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - empty when pointers are equal.
  - full when addresses are equal and wrap bits differ.
- data_count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)). Flags and counts are registered and consistent with each other every cycle.
- prog_full_o = (DEPTH - data_count) < WORDS_PER_EVENT.
- Word counters wr_wc and rd_wc run modulo WORDS_PER_EVENT.
  - An accepted write with wr_wc==WORDS_PER_EVENT-1 completes an event.
  - An accepted read with rd_wc==WORDS_PER_EVENT-1 consumes an event.
- event_count_o: +1 on completion, -1 on consumption; completion and consumption in the same cycle leave it unchanged. It never exceeds DEPTH/WORDS_PER_EVENT.
- Sticky flags clear only on reset.

Optional Feature:
- Macro EVENT_FIFO_ECC_EN.
- Defined:
  - Each stored word carries an even-parity bit computed on write and checked on the read output.
  - An extra output parity_err_o (1 bit) pulses for one cycle, aligned with dout_o, when the check fails.
  - A parity mismatch does not alter data or counts.
- Undefined: no parity storage and no parity_err_o port.

Decomposition:
- Package event_fifo_pkg holds:
  - DATA_W and WORDS_PER_EVENT defaults;
  - the function clog2_ptr;
  - typedef fifo_word_t (logic [DATA_W-1:0]).
- Sub-module fifo_ram: simple dual-port RAM with registered read and no reset on the array, inferable as BRAM.
- Pointer, flag and event-count logic stays in event_fifo.

Test Plan (DEPTH=64, WORDS_PER_EVENT=16):
- Reset, then write 16 words 0x0..0xF -> after the last write event_count_o=1, data_count_o=16, empty_o=0. Reading 16 -> dout_o=0x0..0xF with 1-cycle latency; then event_count_o=0, empty_o=1.
- Fill 64 words -> full_o=1, prog_full_o asserted from data_count 49. A 65th write -> overflow_o=1, data_count_o stays 64.
- Read while empty -> underflow_o=1, dout_o unchanged. A simultaneous write into an empty FIFO -> read rejected, empty_o=0 next cycle.
- Full FIFO with simultaneous rd_en_i and wr_en_i -> read accepted, write rejected, data_count_o=63.
- Stream of 200 words with random rd/wr, checked against a scoreboard -> order preserved across pointer wrap; event_count_o matches the model.
- Reset asserted mid-event after 7 writes -> all counts 0, empty_o=1. Next 16 writes -> event_count_o=1.
